digital_debounce_3v3: RTL

Parametrised multi-channel input conditioner for the 3v3 digital cell set. Each channel takes an asynchronous pin-level signal, synchronises it into the core clock domain, and rejects glitches with a per-channel stability counter. It drives a clean level plus single-cycle rise and fall strobes. It sits between pad-side inputs (GPIO, buttons, external IRQ lines) and core logic.

---
 rtl/digital_debounce_3v3_pkg.sv | 25 ++
 rtl/digital_debounce_3v3_ch.sv | 80 ++++++++
 rtl/digital_debounce_3v3.sv | 59 +++++
 3 files changed

// File: rtl/digital_debounce_3v3_pkg.sv
// Shared definitions for the 3v3 debounce cells: default parameter values,
// legal parameter ranges and the per-channel edge classification.
package digital_debounce_3v3_pkg;

  // Default constants shared with the rest of the 3v3 digital cell set.
  localparam int DEBOUNCE_SYNC_DEF  = 2;
  localparam int DEBOUNCE_CNT_W_DEF = 8;

  // Legal parameter ranges, checked at elaboration by the top level.
  localparam int DEBOUNCE_WIDTH_MIN = 1;
  localparam int DEBOUNCE_WIDTH_MAX = 32;
  localparam int DEBOUNCE_SYNC_MIN  = 2;
  localparam int DEBOUNCE_SYNC_MAX  = 4;
  localparam int DEBOUNCE_CNT_W_MIN = 1;
  localparam int DEBOUNCE_CNT_W_MAX = 31;

  // Outcome of one filter cycle; a single value makes rise and fall mutually
  // exclusive by construction.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

endpackage

// File: rtl/digital_debounce_3v3_ch.sv
// One debounce channel: synchroniser chain, stability counter, filtered
// level and registered rise/fall strobes. i_limit is already normalised
// to be non-zero by the top level.
module digital_debounce_ch_3v3
  import digital_debounce_3v3_pkg::*;
#(
  parameter int   SYNC_STAGES = DEBOUNCE_SYNC_DEF,
  parameter int   CNT_W       = DEBOUNCE_CNT_W_DEF,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rn,
  input  logic             i_en,
  input  logic             i_a,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_q,
  output logic             o_rise,
  output logic             o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_q;
  logic                   r_rise;
  logic                   r_fall;

  logic                   w_s;
  logic [CNT_W:0]         w_cnt_inc;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_q_nxt;
  edge_e                  w_edge;

  assign w_s = r_sync[SYNC_STAGES-1];

  // One extra bit so cnt+1 cannot wrap when LIMIT is all ones.
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);

  // Filter decision: clear on agreement, count on mismatch, commit at limit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    w_cnt_nxt = r_cnt;
    w_q_nxt   = r_q;
    w_edge    = EDGE_NONE;
    if (i_en) begin
      if (w_s == r_q) begin
        w_cnt_nxt = '0;
      end else if (w_cnt_inc < {1'b0, i_limit}) begin
        w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
      end else begin
        w_cnt_nxt = '0;
        w_q_nxt   = w_s;
        w_edge    = w_s ? EDGE_RISE : EDGE_FALL;
      end
    end
  end

  // State registers: synchroniser shifts regardless of enable, filter follows the decision above.
  always_ff @(posedge i_clk) begin
    if (!i_rn) begin
      // NOTE: the synchroniser is reset too, so a stale pre-reset sample can never be filtered into Q.
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_q    <= RESET_VAL;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values and the chain shifts one stage per edge.
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_a};
      r_q    <= w_q_nxt;
      r_cnt  <= w_cnt_nxt;
      r_rise <= (w_edge == EDGE_RISE);
      r_fall <= (w_edge == EDGE_FALL);
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/digital_debounce_3v3.sv
// Multi-channel input conditioner: WIDTH independent debounce channels
// sharing one clock, reset, enable and stability limit.
module digital_debounce_3v3
  import digital_debounce_3v3_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = DEBOUNCE_SYNC_DEF,
  parameter int               CNT_W       = DEBOUNCE_CNT_W_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  input  logic [CNT_W-1:0] LIMIT,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  // Out-of-range parameters are reported as soon as the design is elaborated.
  if (WIDTH < DEBOUNCE_WIDTH_MIN || WIDTH > DEBOUNCE_WIDTH_MAX) begin : g_bad_width
    $error("digital_debounce_3v3: WIDTH=%0d outside %0d..%0d",
           WIDTH, DEBOUNCE_WIDTH_MIN, DEBOUNCE_WIDTH_MAX);
  end
  if (SYNC_STAGES < DEBOUNCE_SYNC_MIN || SYNC_STAGES > DEBOUNCE_SYNC_MAX) begin : g_bad_sync
    $error("digital_debounce_3v3: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, DEBOUNCE_SYNC_MIN, DEBOUNCE_SYNC_MAX);
  end
  if (CNT_W < DEBOUNCE_CNT_W_MIN || CNT_W > DEBOUNCE_CNT_W_MAX) begin : g_bad_cnt_w
    $error("digital_debounce_3v3: CNT_W=%0d outside %0d..%0d",
           CNT_W, DEBOUNCE_CNT_W_MIN, DEBOUNCE_CNT_W_MAX);
  end

  logic [CNT_W-1:0] w_limit_eff;

  // A limit of zero behaves as one: every channel still needs one mismatch cycle.
  always_comb begin
    w_limit_eff = (LIMIT == '0) ? CNT_W'(1) : LIMIT;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    digital_debounce_ch_3v3 #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RESET_VAL   (RESET_VAL[i])
    ) u_ch (
      .i_clk   (CLK),
      .i_rn    (RN),
      .i_en    (EN),
      .i_a     (A[i]),
      .i_limit (w_limit_eff),
      .o_q     (Q[i]),
      .o_rise  (RISE[i]),
      .o_fall  (FALL[i])
    );
  end

endmodule
